// File: rtl/slurm16_cpu_pkg.sv
// Shared constants for the slurm16 CPU pipeline blocks.
package slurm16_cpu_pkg;
  localparam int REG_BITS_DEF = 4;
  localparam int BITS_DEF     = 16;
  localparam int REG_ZERO     = 0;
endpackage

// File: rtl/slurm16_cpu_writeback_if.sv
// Writeback stage bus: ALU result handshake, load issue/return, hazard query, regfile write port.
interface slurm16_cpu_writeback_if
  import slurm16_cpu_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DEF,
  parameter int BITS     = BITS_DEF
);
  logic                alu_valid;
  logic [REG_BITS-1:0] alu_reg;
  logic [BITS-1:0]     alu_data;
  logic                alu_ready;
  logic                load_issue;
  logic [REG_BITS-1:0] load_issue_reg;
  logic                load_valid;
  logic [REG_BITS-1:0] load_reg;
  logic [BITS-1:0]     load_data;
  logic [REG_BITS-1:0] hazA_reg;
  logic [REG_BITS-1:0] hazB_reg;
  logic                hazA;
  logic                hazB;
  logic [REG_BITS-1:0] regIn;
  logic [BITS-1:0]     regIn_data;

  modport slave (
    input  alu_valid, alu_reg, alu_data, load_issue, load_issue_reg,
           load_valid, load_reg, load_data, hazA_reg, hazB_reg,
    output alu_ready, hazA, hazB, regIn, regIn_data
  );

  modport master (
    output alu_valid, alu_reg, alu_data, load_issue, load_issue_reg,
           load_valid, load_reg, load_data, hazA_reg, hazB_reg,
    input  alu_ready, hazA, hazB, regIn, regIn_data
  );
endinterface

// File: rtl/slurm16_cpu_wb_fifo.sv
// Small sync FIFO for ALU results; exposes every slot's register index so
// the hazard logic can see destinations still waiting to be written.
module slurm16_cpu_wb_fifo #(
  parameter int DEPTH  = 2,
  parameter int REG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [REG_W-1:0]             push_reg,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [REG_W-1:0]             head_reg,
  output logic [DATA_W-1:0]            head_data,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0][REG_W-1:0]  entry_reg,
  output logic [DEPTH-1:0]             entry_vld
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic [DEPTH-1:0][REG_W-1:0]  reg_mem_q, reg_mem_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem_q, data_mem_d;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    reg_mem_d  = reg_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      reg_mem_d[wr_ptr_q]  = push_reg;
      data_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: entry_vld masks stale slots.
  always_ff @(posedge clk) begin
    reg_mem_q  <= reg_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign head_reg  = reg_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign entry_reg = reg_mem_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    localparam logic [PW-1:0] IDX = PW'(i);
    logic [PW-1:0] off;
    assign off          = IDX - rd_ptr_q;
    assign entry_vld[i] = ({1'b0, off} < count_q);
  end
endmodule

// File: rtl/slurm16_cpu_writeback.sv
// Writeback stage: arbitrates loads, buffered and direct ALU results onto the
// single regfile write port, and tracks outstanding loads for decode hazards.
module slurm16_cpu_writeback
  import slurm16_cpu_pkg::*;
#(
  parameter int REG_BITS   = REG_BITS_DEF,
  parameter int BITS       = BITS_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input logic                    CLK,
  input logic                    RSTb,
  slurm16_cpu_writeback_if.slave wb
);
  localparam int NREG = 2 ** REG_BITS;
  localparam logic [REG_BITS-1:0] R0 = REG_BITS'(REG_ZERO);

  logic                               alu_acc, sel_pop, sel_byp, fifo_push;
  logic                               fifo_full, fifo_empty;
  logic [REG_BITS-1:0]                head_reg;
  logic [BITS-1:0]                    head_data;
  logic [FIFO_DEPTH-1:0][REG_BITS-1:0] entry_reg;
  logic [FIFO_DEPTH-1:0]              entry_vld;
  logic [REG_BITS-1:0]                reg_in_q, reg_in_d;
  logic [BITS-1:0]                    reg_data_q, reg_data_d;
  logic [NREG-1:0]                    busy_q, busy_d;
  logic                               hit_a, hit_b;

  slurm16_cpu_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .REG_W (REG_BITS),
    .DATA_W(BITS)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RSTb),
    .push     (fifo_push),
    .push_reg (wb.alu_reg),
    .push_data(wb.alu_data),
    .pop      (sel_pop),
    .head_reg (head_reg),
    .head_data(head_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .entry_reg(entry_reg),
    .entry_vld(entry_vld)
  );

  assign wb.alu_ready = !fifo_full;
  assign alu_acc      = wb.alu_valid && !fifo_full;
  assign sel_pop      = !wb.load_valid && !fifo_empty;
  assign sel_byp      = !wb.load_valid && fifo_empty && alu_acc;
  assign fifo_push    = alu_acc && !sel_byp;

  always_comb begin
    reg_in_d   = R0;
    reg_data_d = '0;
    if (wb.load_valid) begin
      reg_in_d   = wb.load_reg;
      reg_data_d = wb.load_data;
    end else if (sel_pop) begin
      reg_in_d   = head_reg;
      reg_data_d = head_data;
    end else if (sel_byp) begin
      reg_in_d   = wb.alu_reg;
      reg_data_d = wb.alu_data;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (wb.load_valid) busy_d[wb.load_reg] = 1'b0;
    if (wb.load_issue && wb.load_issue_reg != R0) busy_d[wb.load_issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RSTb) begin
      reg_in_q   <= R0;
      reg_data_q <= '0;
      busy_q     <= '0;
    end else begin
      reg_in_q   <= reg_in_d;
      reg_data_q <= reg_data_d;
      busy_q     <= busy_d;
    end
  end

  assign wb.regIn      = reg_in_q;
  assign wb.regIn_data = reg_data_q;

  // regIn term: the regfile still returns old data during its write cycle.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_vld[i] && entry_reg[i] == wb.hazA_reg) hit_a = 1'b1;
      if (entry_vld[i] && entry_reg[i] == wb.hazB_reg) hit_b = 1'b1;
    end
    wb.hazA = (wb.hazA_reg != R0) &&
              (busy_q[wb.hazA_reg] || hit_a || reg_in_q == wb.hazA_reg);
    wb.hazB = (wb.hazB_reg != R0) &&
              (busy_q[wb.hazB_reg] || hit_b || reg_in_q == wb.hazB_reg);
  end
endmodule

// File: tb/tb_slurm16_cpu_writeback.sv
// Directed cycle-by-cycle vectors for the writeback stage plus a mid-run reset sequence.
module tb_slurm16_cpu_writeback;
  logic CLK = 1'b0;
  logic RSTb;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  slurm16_cpu_writeback_if #(.REG_BITS(4), .BITS(16)) wb ();

  slurm16_cpu_writeback #(.REG_BITS(4), .BITS(16), .FIFO_DEPTH(2)) dut (
    .CLK (CLK),
    .RSTb(RSTb),
    .wb  (wb)
  );

  typedef struct {
    logic        av;  logic [3:0] ar;  logic [15:0] ad;
    logic        lv;  logic [3:0] lr;  logic [15:0] ld;
    logic        li;  logic [3:0] lir;
    logic [3:0]  ha;  logic [3:0] hb;
    logic        e_rdy, e_ha, e_hb;
    logic [3:0]  e_reg; logic [15:0] e_dat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                              input logic lv, input logic [3:0] lr, input logic [15:0] ld,
                              input logic li, input logic [3:0] lir,
                              input logic [3:0] ha, input logic [3:0] hb,
                              input logic e_rdy, input logic e_ha, input logic e_hb,
                              input logic [3:0] e_reg, input logic [15:0] e_dat);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld;
    v.li = li; v.lir = lir; v.ha = ha; v.hb = hb;
    v.e_rdy = e_rdy; v.e_ha = e_ha; v.e_hb = e_hb; v.e_reg = e_reg; v.e_dat = e_dat;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb.alu_valid = v.av; wb.alu_reg = v.ar; wb.alu_data = v.ad;
    wb.load_valid = v.lv; wb.load_reg = v.lr; wb.load_data = v.ld;
    wb.load_issue = v.li; wb.load_issue_reg = v.lir;
    wb.hazA_reg = v.ha; wb.hazB_reg = v.hb;
  endtask

  // Inputs settle 1ns after the edge, outputs are sampled 1ns later.
  task automatic apply_check(input string tag, input int idx, input vec_t v);
    drive(v);
    #1;
    chk({tag, ".ready"}, idx, 32'(wb.alu_ready), 32'(v.e_rdy));
    chk({tag, ".hazA"},  idx, 32'(wb.hazA),      32'(v.e_ha));
    chk({tag, ".hazB"},  idx, 32'(wb.hazB),      32'(v.e_hb));
    chk({tag, ".regIn"}, idx, 32'(wb.regIn),     32'(v.e_reg));
    chk({tag, ".data"},  idx, 32'(wb.regIn_data), 32'(v.e_dat));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t idle;
    RSTb = 1'b1;
    idle = '{default: '0};
    drive(idle);
    repeat (3) @(posedge CLK);
    #1;
    RSTb = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++)
      add(0,0,0, 0,0,0, 0,0, 3,5, 1,0,0, 0,16'h0);
    // 2: uncontested ALU write, hazard only in the write cycle
    add(1,3,16'h1234, 0,0,0, 0,0, 3,0, 1,0,0, 0,16'h0);
    add(0,0,0,        0,0,0, 0,0, 3,0, 1,1,0, 3,16'h1234);
    add(0,0,0,        0,0,0, 0,0, 3,0, 1,0,0, 0,16'h0);
    // 3: load beats ALU, ALU result buffered one cycle
    add(1,6,16'h0001, 1,5,16'hBEEF, 0,0, 6,5, 1,0,0, 0,16'h0);
    add(0,0,0,        0,0,0,        0,0, 6,5, 1,1,1, 5,16'hBEEF);
    add(0,0,0,        0,0,0,        0,0, 6,5, 1,1,0, 6,16'h0001);
    add(0,0,0,        0,0,0,        0,0, 6,5, 1,0,0, 0,16'h0);
    // 4: three loads vs three ALU results, FIFO fills, r9 held
    add(1,7,16'h7777, 1,1,16'h1111, 0,0, 9,7, 1,0,0, 0,16'h0);
    add(1,8,16'h8888, 1,2,16'h2222, 0,0, 9,7, 1,0,1, 1,16'h1111);
    add(1,9,16'h9999, 1,4,16'h4444, 0,0, 9,7, 0,0,1, 2,16'h2222);
    add(1,9,16'h9999, 0,0,0,        0,0, 9,7, 0,0,1, 4,16'h4444);
    add(1,9,16'h9999, 0,0,0,        0,0, 9,7, 1,0,1, 7,16'h7777);
    add(0,0,0,        0,0,0,        0,0, 9,7, 1,1,0, 8,16'h8888);
    add(0,0,0,        0,0,0,        0,0, 9,7, 1,1,0, 9,16'h9999);
    add(0,0,0,        0,0,0,        0,0, 9,7, 1,0,0, 0,16'h0);
    // 5: scoreboard, then same-cycle issue+return keeps busy
    add(0,0,0, 0,0,0,        1,4, 4,2, 1,0,0, 0,16'h0);
    add(0,0,0, 0,0,0,        0,0, 4,2, 1,1,0, 0,16'h0);
    add(0,0,0, 0,0,0,        0,0, 4,2, 1,1,0, 0,16'h0);
    add(0,0,0, 1,4,16'hAAAA, 0,0, 4,2, 1,1,0, 0,16'h0);
    add(0,0,0, 0,0,0,        0,0, 4,2, 1,1,0, 4,16'hAAAA);
    add(0,0,0, 0,0,0,        0,0, 4,2, 1,0,0, 0,16'h0);
    add(0,0,0, 1,4,16'hBBBB, 1,4, 4,2, 1,0,0, 0,16'h0);
    add(0,0,0, 0,0,0,        0,0, 4,2, 1,1,0, 4,16'hBBBB);
    add(0,0,0, 0,0,0,        0,0, 4,2, 1,1,0, 0,16'h0);
    add(0,0,0, 1,4,16'hCCCC, 1,0, 4,0, 1,1,0, 0,16'h0);
    add(0,0,0, 0,0,0,        0,0, 4,0, 1,1,0, 4,16'hCCCC);
    add(0,0,0, 0,0,0,        0,0, 4,0, 1,0,0, 0,16'h0);

    foreach (tbl[i]) apply_check("vec", i, tbl[i]);

    // 6: reset with two buffered entries and busy[2] set
    tbl.delete();
    add(1,5,16'h5555, 1,1,16'h1010, 1,2, 2,5, 1,0,0, 0,16'h0);
    add(1,6,16'h6666, 1,3,16'h3030, 0,0, 2,5, 1,1,1, 1,16'h1010);
    foreach (tbl[i]) apply_check("rst_fill", i, tbl[i]);
    drive(idle);
    wb.hazA_reg = 4'd2; wb.hazB_reg = 4'd5;
    RSTb = 1'b1;
    #1;
    chk("rst_pre.ready", 0, 32'(wb.alu_ready), 32'd0);
    chk("rst_pre.hazA",  0, 32'(wb.hazA),      32'd1);
    chk("rst_pre.regIn", 0, 32'(wb.regIn),     32'd3);
    @(posedge CLK);
    #1;
    RSTb = 1'b0;
    #1;
    chk("rst_post.ready", 0, 32'(wb.alu_ready), 32'd1);
    chk("rst_post.hazA",  0, 32'(wb.hazA),      32'd0);
    chk("rst_post.hazB",  0, 32'(wb.hazB),      32'd0);
    chk("rst_post.regIn", 0, 32'(wb.regIn),     32'd0);
    chk("rst_post.data",  0, 32'(wb.regIn_data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #2;
      chk("rst_idle.regIn", i, 32'(wb.regIn),      32'd0);
      chk("rst_idle.data",  i, 32'(wb.regIn_data), 32'd0);
      chk("rst_idle.hazA",  i, 32'(wb.hazA),       32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
